// File: rtl/mem_pipe_module.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_pipe_module
// Description : Byte-masked line memory with pipelined reads and an in-order
//               read-response FIFO protected by registered credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_pipe_module #(
    parameter int DATA_WIDTH  = 512,
    parameter int MASK_WIDTH  = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH  = 34,
    parameter int OFFSET_BITS = 6,
    parameter int DEPTH       = 256,
    parameter int READ_LAT    = 1,
    parameter int RESP_DEPTH  = 4,
    parameter int ID_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wren,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_din,
    input  logic [MASK_WIDTH-1:0] i_req_byte_mask,
    input  logic [ID_WIDTH-1:0]   i_req_id,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_dout,
    output logic [ID_WIDTH-1:0]   o_resp_id,
    output logic                  o_resp_err
);

    localparam int IDX_W  = ADDR_WIDTH - OFFSET_BITS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int STAGES = READ_LAT + 1;

    logic [IDX_W-1:0]      req_idx;
    logic [MEM_AW-1:0]     mem_addr;
    logic                  in_range;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] rd_line;
    logic                  unused_offset;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  pipe_valid [STAGES];
    logic [DATA_WIDTH-1:0] pipe_data  [STAGES];
    logic [ID_WIDTH-1:0]   pipe_id    [STAGES];
    logic                  pipe_err   [STAGES];

    logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id   [RESP_DEPTH];
    logic                  fifo_err  [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic                  ready_q;
    logic                  push;
    logic                  pop;
    logic                  resp_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_idx       = i_req_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign mem_addr      = req_idx[MEM_AW-1:0];
    assign in_range      = (64'(req_idx) < 64'(DEPTH));
    assign unused_offset = ^i_req_addr[OFFSET_BITS-1:0];

    assign accept    = i_req_valid & ready_q;
    assign rd_accept = accept & ~i_req_wren;
    assign wr_accept = accept & i_req_wren & in_range;
    assign rd_line   = in_range ? mem[mem_addr] : '0;

    // Array contents survive reset, so it lives in its own reset-free process.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (i_req_byte_mask[b]) begin
                    mem[mem_addr][b*8 +: 8] <= i_req_din[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 samples the array at the acceptance edge; READ_LAT stages follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_data[s]  <= '0;
                pipe_id[s]    <= '0;
                pipe_err[s]   <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            pipe_data[0]  <= rd_line;
            pipe_id[0]    <= i_req_id;
            pipe_err[0]   <= ~in_range;
            for (int s = 1; s < STAGES; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_data[s]  <= pipe_data[s-1];
                pipe_id[s]    <= pipe_id[s-1];
                pipe_err[s]   <= pipe_err[s-1];
            end
        end
    end

    assign push       = pipe_valid[STAGES-1];
    assign resp_valid = (fifo_count != '0);
    assign pop        = resp_valid & i_resp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= pipe_data[STAGES-1];
            fifo_id[wr_ptr]   <= pipe_id[STAGES-1];
            fifo_err[wr_ptr]  <= pipe_err[STAGES-1];
        end
    end

    // Credits cover pipeline plus FIFO, so a FIFO slot is reserved at acceptance.
    assign outstanding_next = outstanding + CNT_W'(rd_accept) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            ready_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding_next;
            ready_q     <= (outstanding_next < CNT_W'(RESP_DEPTH));
        end
    end

    assign o_req_ready  = ready_q;
    assign o_resp_valid = resp_valid;
    assign o_resp_dout  = resp_valid ? fifo_data[rd_ptr] : '0;
    assign o_resp_id    = resp_valid ? fifo_id[rd_ptr] : '0;
    assign o_resp_err   = resp_valid ? fifo_err[rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mem_pipe_module.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_pipe_module
// Description : Self-checking bench for mem_pipe_module against a line-level
//               memory model and an in-order expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_pipe_module;

    localparam int DW    = 512;
    localparam int MW    = DW / 8;
    localparam int AW    = 34;
    localparam int OB    = 6;
    localparam int DEPTH = 256;
    localparam int RL    = 1;
    localparam int RD    = 4;
    localparam int IDW   = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_req_valid;
    logic           o_req_ready;
    logic           i_req_wren;
    logic [AW-1:0]  i_req_addr;
    logic [DW-1:0]  i_req_din;
    logic [MW-1:0]  i_req_byte_mask;
    logic [IDW-1:0] i_req_id;
    logic           o_resp_valid;
    logic           i_resp_ready;
    logic [DW-1:0]  o_resp_dout;
    logic [IDW-1:0] o_resp_id;
    logic           o_resp_err;

    always #5 clk = ~clk;

    mem_pipe_module #(
        .DATA_WIDTH (DW),
        .MASK_WIDTH (MW),
        .ADDR_WIDTH (AW),
        .OFFSET_BITS(OB),
        .DEPTH      (DEPTH),
        .READ_LAT   (RL),
        .RESP_DEPTH (RD),
        .ID_WIDTH   (IDW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_wren     (i_req_wren),
        .i_req_addr     (i_req_addr),
        .i_req_din      (i_req_din),
        .i_req_byte_mask(i_req_byte_mask),
        .i_req_id       (i_req_id),
        .o_resp_valid   (o_resp_valid),
        .i_resp_ready   (i_resp_ready),
        .o_resp_dout    (o_resp_dout),
        .o_resp_id      (o_resp_id),
        .o_resp_err     (o_resp_err)
    );

    typedef struct {
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
        logic           err;
    } resp_t;

    resp_t         exp_q[$];
    logic [DW-1:0] model_mem [int];
    int            checks = 0;
    int            errors = 0;
    bit            last_acc;

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic set_req(input bit wren, input int idx, input logic [DW-1:0] din,
                           input logic [MW-1:0] mask, input logic [IDW-1:0] id);
        i_req_valid     = 1'b1;
        i_req_wren      = wren;
        i_req_addr      = (AW'(idx) << OB) | AW'($urandom_range(0, (1 << OB) - 1));
        i_req_din       = din;
        i_req_byte_mask = mask;
        i_req_id        = id;
    endtask

    task automatic set_idle();
        i_req_valid = 1'b0;
    endtask

    // Advance one clock, applying the handshakes that occur at this edge to the model.
    task automatic tick();
        bit            acc;
        bit            pop;
        int            idx;
        logic [DW-1:0] line;
        resp_t         r;
        acc = i_req_valid && o_req_ready;
        pop = o_resp_valid && i_resp_ready;
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            idx = int'(i_req_addr >> OB);
            if (i_req_wren) begin
                if (idx < DEPTH) begin
                    line = model_mem.exists(idx) ? model_mem[idx] : 'x;
                    for (int b = 0; b < MW; b++)
                        if (i_req_byte_mask[b]) line[b*8 +: 8] = i_req_din[b*8 +: 8];
                    model_mem[idx] = line;
                end
            end else begin
                r.id = i_req_id;
                if (idx < DEPTH) begin
                    r.data = model_mem[idx];
                    r.err  = 1'b0;
                end else begin
                    r.data = '0;
                    r.err  = 1'b1;
                end
                exp_q.push_back(r);
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b1;
        i_resp_ready = 1'b0;
        i_req_wren   = 1'b0;
        i_req_addr   = '0;
        i_req_din    = '0;
        i_req_byte_mask = '0;
        i_req_id     = '0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", o_req_ready); end
        checks++; if (o_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_resp_valid); end
        checks++; if (o_resp_dout !== '0) begin errors++; $display("FAIL rst_dout: got %h want 0", o_resp_dout); end
        checks++; if (o_resp_id !== '0) begin errors++; $display("FAIL rst_id: got %0d want 0", o_resp_id); end
        checks++; if (o_resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_resp_err); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hold: got %b want 0", o_req_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", o_req_ready); end
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, i, rand_line(), '1, '0);
            tick();
        end
        set_idle();
    endtask

    task automatic test_write_read();
        int lat = 0;
        i_resp_ready = 1'b1;
        set_req(1'b1, 1, {64{8'hA5}}, '1, '0);
        tick();
        set_req(1'b0, 1, '0, '0, 4'd3);
        tick();
        set_idle();
        while (!o_resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checks++; if (lat != RL + 1) begin errors++; $display("FAIL wr_rd_latency: got %0d want %0d", lat, RL + 1); end
        checks++;
        if (o_resp_dout !== {64{8'hA5}} || o_resp_id !== 4'd3 || o_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_resp: got id=%0d err=%b dout=%h want id=3 err=0 dout=a5..", o_resp_id, o_resp_err, o_resp_dout);
        end
        tick();
    endtask

    task automatic test_byte_mask();
        int lat = 0;
        i_resp_ready = 1'b1;
        set_req(1'b1, 2, {64{8'h11}}, '1, '0);
        tick();
        set_req(1'b1, 2, {64{8'h22}}, MW'(1), '0);
        tick();
        set_req(1'b0, 2, '0, '0, 4'd7);
        tick();
        set_idle();
        while (!o_resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (o_resp_valid !== 1'b1 || o_resp_dout !== {{63{8'h11}}, 8'h22} || o_resp_id !== 4'd7 || o_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL byte_mask: got valid=%b id=%0d err=%b dout=%h want id=7 err=0 dout=11..1122",
                     o_resp_valid, o_resp_id, o_resp_err, o_resp_dout);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        int            lat = 0;
        logic [DW-1:0] line0;
        i_resp_ready = 1'b1;
        line0 = model_mem[0];
        set_req(1'b0, DEPTH, rand_line(), '1, 4'd5);
        tick();
        set_idle();
        while (!o_resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != RL + 1 || o_resp_dout !== '0 || o_resp_id !== 4'd5 || o_resp_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got lat=%0d id=%0d err=%b dout=%h want lat=%0d id=5 err=1 dout=0",
                     lat, o_resp_id, o_resp_err, o_resp_dout, RL + 1);
        end
        tick();
        set_req(1'b1, DEPTH, ~line0, '1, '0);
        tick();
        set_req(1'b0, 0, '0, '0, 4'd6);
        tick();
        set_idle();
        lat = 0;
        while (!o_resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (o_resp_valid !== 1'b1 || o_resp_dout !== line0 || o_resp_id !== 4'd6 || o_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_write: got valid=%b id=%0d err=%b dout=%h want id=6 err=0 dout=%h",
                     o_resp_valid, o_resp_id, o_resp_err, o_resp_dout, line0);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int             n_acc = 0;
        int             pops  = 0;
        int             cyc   = 0;
        logic [DW-1:0]  snap_d;
        logic [IDW-1:0] snap_id;
        logic           snap_err;
        i_resp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (n_acc < 6) set_req(1'b0, n_acc % 8, '0, '0, IDW'(8 + n_acc));
            tick();
            if (last_acc) n_acc++;
        end
        checks++; if (n_acc != RD) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", n_acc, RD); end
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", o_req_ready); end
        checks++;
        if (o_resp_valid !== 1'b1 || o_resp_id !== 4'd8 || o_resp_dout !== exp_q[0].data || o_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_head: got valid=%b id=%0d err=%b want valid=1 id=8 err=0", o_resp_valid, o_resp_id, o_resp_err);
        end
        snap_d   = o_resp_dout;
        snap_id  = o_resp_id;
        snap_err = o_resp_err;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_resp_valid !== 1'b1 || {o_resp_dout, o_resp_id, o_resp_err} !== {snap_d, snap_id, snap_err}) begin
                errors++;
                $display("FAIL bp_stable: got valid=%b id=%0d err=%b want valid=1 id=%0d err=%b", o_resp_valid, o_resp_id, o_resp_err, snap_id, snap_err);
            end
        end
        i_resp_ready = 1'b1;
        while ((n_acc < 6 || exp_q.size() != 0) && cyc < 40) begin
            if (n_acc < 6) set_req(1'b0, n_acc % 8, '0, '0, IDW'(8 + n_acc));
            else set_idle();
            if (o_resp_valid) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_spurious: got id=%0d want no response", o_resp_id);
                end else if ({o_resp_dout, o_resp_id, o_resp_err} !== {exp_q[0].data, exp_q[0].id, exp_q[0].err}) begin
                    errors++;
                    $display("FAIL bp_order: got id=%0d err=%b dout=%h want id=%0d err=%b dout=%h",
                             o_resp_id, o_resp_err, o_resp_dout, exp_q[0].id, exp_q[0].err, exp_q[0].data);
                end
            end
            tick();
            if (last_acc) n_acc++;
            cyc++;
        end
        set_idle();
        checks++; if (n_acc != 6 || pops != 6) begin errors++; $display("FAIL bp_drain: got acc=%0d pops=%0d want 6 and 6", n_acc, pops); end
    endtask

    task automatic test_random();
        int idx;
        for (int c = 0; c < 400; c++) begin
            i_resp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                idx = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
                set_req($urandom_range(0, 2) == 0, idx, rand_line(), {$urandom(), $urandom()}, IDW'($urandom()));
            end else begin
                set_idle();
            end
            if (o_resp_valid && i_resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got id=%0d want no response", o_resp_id);
                end else if ({o_resp_dout, o_resp_id, o_resp_err} !== {exp_q[0].data, exp_q[0].id, exp_q[0].err}) begin
                    errors++;
                    $display("FAIL rand_resp: got id=%0d err=%b dout=%h want id=%0d err=%b dout=%h",
                             o_resp_id, o_resp_err, o_resp_dout, exp_q[0].id, exp_q[0].err, exp_q[0].data);
                end
            end
            tick();
        end
        set_idle();
        i_resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (o_resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got id=%0d want no response", o_resp_id);
                end else if ({o_resp_dout, o_resp_id, o_resp_err} !== {exp_q[0].data, exp_q[0].id, exp_q[0].err}) begin
                    errors++;
                    $display("FAIL rand_drain: got id=%0d err=%b dout=%h want id=%0d err=%b dout=%h",
                             o_resp_id, o_resp_err, o_resp_dout, exp_q[0].id, exp_q[0].err, exp_q[0].data);
                end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_throughput();
        int issued = 0;
        int seen   = 0;
        int t      = 0;
        i_resp_ready = 1'b1;
        while (seen < 100 && t < 300) begin
            if (issued < 100) set_req(1'b0, int'($urandom_range(0, 7)), '0, '0, IDW'(issued));
            else set_idle();
            if (o_resp_valid) begin
                seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL tput_spurious: got id=%0d want no response", o_resp_id);
                end else if ({o_resp_dout, o_resp_id, o_resp_err} !== {exp_q[0].data, exp_q[0].id, exp_q[0].err}) begin
                    errors++;
                    $display("FAIL tput_resp: got id=%0d err=%b dout=%h want id=%0d err=%b dout=%h",
                             o_resp_id, o_resp_err, o_resp_dout, exp_q[0].id, exp_q[0].err, exp_q[0].data);
                end
            end
            if (seen == 100) break;
            tick();
            if (last_acc) issued++;
            t++;
            if (t == 100) begin
                checks++;
                if (issued != 100) begin errors++; $display("FAIL tput_stall: got %0d accepted in 100 cycles want 100", issued); end
            end
        end
        set_idle();
        checks++; if (t != 100 + RL + 1) begin errors++; $display("FAIL tput_cycles: got %0d want %0d", t, 100 + RL + 1); end
        tick();
        checks++; if (exp_q.size() != 0 || o_resp_valid !== 1'b0) begin errors++; $display("FAIL tput_left: got pending=%0d valid=%b want 0 and 0", exp_q.size(), o_resp_valid); end
    endtask

    task automatic test_reset_inflight();
        int n_acc = 0;
        int cyc   = 0;
        i_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, i, '0, '0, IDW'(i + 1));
            tick();
        end
        set_idle();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b0) begin errors++; $display("FAIL rsti_during: got valid=%b ready=%b want 0 0", o_resp_valid, o_req_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        i_resp_ready = 1'b1;
        tick();
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rsti_ready: got %b want 1", o_req_ready); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (o_resp_valid !== 1'b0) begin errors++; $display("FAIL rsti_stale: got valid=%b id=%0d want valid=0", o_resp_valid, o_resp_id); end
            tick();
        end
        while ((n_acc < 8 || exp_q.size() != 0) && cyc < 40) begin
            if (n_acc < 8) set_req(1'b0, n_acc, '0, '0, IDW'(n_acc));
            else set_idle();
            if (o_resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rsti_spurious: got id=%0d want no response", o_resp_id);
                end else if ({o_resp_dout, o_resp_id, o_resp_err} !== {exp_q[0].data, exp_q[0].id, exp_q[0].err}) begin
                    errors++;
                    $display("FAIL rsti_readback: got id=%0d err=%b dout=%h want id=%0d err=%b dout=%h",
                             o_resp_id, o_resp_err, o_resp_dout, exp_q[0].id, exp_q[0].err, exp_q[0].data);
                end
            end
            tick();
            if (last_acc) n_acc++;
            cyc++;
        end
        set_idle();
        checks++; if (n_acc != 8 || exp_q.size() != 0) begin errors++; $display("FAIL rsti_drain: got acc=%0d pending=%0d want 8 0", n_acc, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_out_of_range();
        test_backpressure();
        test_random();
        test_throughput();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
